// File: rtl/tt_um_nibble_fifo.sv
// Four-entry byte FIFO with synchronized write/read strobes and a nibble-swapped registered head.
// Define NIBBLE_FIFO_PARITY_EN to drive the even-parity bit on uio_out[6].
module tt_um_nibble_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] r_mem [0:3];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count;
    logic       r_wr_s1, r_wr_s2, r_wr_d, r_wr_arm;
    logic       r_rd_s1, r_rd_s2, r_rd_d, r_rd_arm;
    logic [1:0] r_fill;
    logic       r_full, r_empty, r_ovf, r_udf;
    logic [7:0] r_uo;

    logic       w_wr_p, w_rd_p, w_push, w_pop, w_par;
    logic [1:0] w_wptr_n, w_rptr_n;
    logic [2:0] w_count_n;
    logic [7:0] w_head, w_uo_n;
    logic       w_unused;

    assign w_unused = &{1'b0, uio_in[7:2]};

    // Edge detection is armed only after the synchronized strobe has been seen low,
    // so a strobe held high from reset cannot masquerade as a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_s1  <= 1'b0;
            r_wr_s2  <= 1'b0;
            r_wr_d   <= 1'b0;
            r_wr_arm <= 1'b0;
            r_rd_s1  <= 1'b0;
            r_rd_s2  <= 1'b0;
            r_rd_d   <= 1'b0;
            r_rd_arm <= 1'b0;
            r_fill   <= '0;
        end else begin
            r_wr_s1  <= uio_in[0];
            r_wr_s2  <= r_wr_s1;
            r_wr_d   <= r_wr_s2;
            r_wr_arm <= r_wr_arm | (r_fill[1] & ~r_wr_s2);
            r_rd_s1  <= uio_in[1];
            r_rd_s2  <= r_rd_s1;
            r_rd_d   <= r_rd_s2;
            r_rd_arm <= r_rd_arm | (r_fill[1] & ~r_rd_s2);
            r_fill   <= {r_fill[0], 1'b1};
        end
    end

    assign w_wr_p = ena & r_wr_arm & r_wr_s2 & ~r_wr_d;
    assign w_rd_p = ena & r_rd_arm & r_rd_s2 & ~r_rd_d;

    always_comb begin
        w_push    = w_wr_p & ((r_count != 3'd4) | w_rd_p);
        w_pop     = w_rd_p & (r_count != 3'd0);
        w_wptr_n  = r_wptr + {1'b0, w_push};
        w_rptr_n  = r_rptr + {1'b0, w_pop};
        w_count_n = r_count + {2'b00, w_push} - {2'b00, w_pop};
        // The new head slot may be the one being written this cycle (push into empty).
        if (w_count_n == 3'd0)
            w_head = '0;
        else if (w_push && (r_wptr == w_rptr_n))
            w_head = ui_in;
        else
            w_head = r_mem[w_rptr_n];
        w_uo_n = {w_head[3:0], w_head[7:4]};
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= ui_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_uo    <= '0;
        end else begin
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_rptr_n;
            r_count <= w_count_n;
            r_full  <= (w_count_n == 3'd4);
            r_empty <= (w_count_n == 3'd0);
            r_ovf   <= r_ovf | (w_wr_p & ~w_rd_p & (r_count == 3'd4));
            r_udf   <= r_udf | (w_rd_p & (r_count == 3'd0));
            r_uo    <= w_uo_n;
        end
    end

`ifdef NIBBLE_FIFO_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par <= 1'b0;
        else
            r_par <= ^w_uo_n;
    end
    assign w_par = r_par;
`else
    assign w_par = 1'b0;
`endif

    assign uo_out  = r_uo;
    assign uio_out = {1'b0, w_par, r_udf, r_ovf, r_empty, r_full, 2'b00};
    assign uio_oe  = 8'b1111_1100;

endmodule

// File: tb/tb_tt_um_nibble_fifo.sv
// Directed bench for tt_um_nibble_fifo with a queue-based scoreboard of FIFO contents.
module tb_tt_um_nibble_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = '0;
    logic [7:0] uio_in = '0;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    tt_um_nibble_fifo dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_uo();
        logic [7:0] h;
        if (q.size() == 0) return 8'h00;
        h = q[0];
        return {h[3:0], h[7:4]};
    endfunction

    function automatic logic [7:0] exp_uio();
        logic p;
        logic [7:0] u;
        u = exp_uo();
`ifdef NIBBLE_FIFO_PARITY_EN
        p = ^u;
`else
        p = 1'b0;
`endif
        return {1'b0, p, m_udf, m_ovf, (q.size() == 0), (q.size() == 4), 2'b00};
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".uo"}, uo_out, exp_uo());
        check({tag, ".flags"}, uio_out, exp_uio());
    endtask

    // Drive one strobe event; checks the head has not moved at E1 and has at E2.
    task automatic op(input string tag, input bit wr, input bit rd, input logic [7:0] d);
        logic [7:0] pre_uo;
        int cnt;
        pre_uo = exp_uo();
        @(negedge clk);
        ui_in  = d;
        uio_in = {6'b0, rd, wr};
        cnt = q.size();
        if (wr && rd) begin
            if (cnt == 0) m_udf = 1'b1;
            else void'(q.pop_front());
            q.push_back(d);
        end else if (wr) begin
            if (cnt < 4) q.push_back(d);
            else m_ovf = 1'b1;
        end else if (rd) begin
            if (cnt > 0) void'(q.pop_front());
            else m_udf = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, ".early"}, uo_out, pre_uo);
        @(posedge clk);
        #1;
        check_model(tag);
        @(negedge clk);
        uio_in = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.uo", uo_out, 8'h00);
        check("rst.flags", uio_out, 8'h08);
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        check("oe", uio_oe, 8'hFC);
        check_model("idle");

        op("wrA5", 1, 0, 8'hA5);
        check("wrA5.lit", uo_out, 8'h5A);

        do_reset();
        op("wr12", 1, 0, 8'h12);
        op("wr34", 1, 0, 8'h34);
        op("wr56", 1, 0, 8'h56);
        op("wr78", 1, 0, 8'h78);
        check("full.lit", uio_out & 8'h04, 8'h04);
        check("full.uo", uo_out, 8'h21);
        op("wr9A", 1, 0, 8'h9A);
        check("ovf.lit", uio_out & 8'h10, 8'h10);
        op("rd1", 0, 1, 8'h00);
        check("rd1.lit", uo_out, 8'h43);
        op("rd2", 0, 1, 8'h00);
        op("rd3", 0, 1, 8'h00);
        op("rd4", 0, 1, 8'h00);
        check("rd4.lit", uo_out, 8'h00);
        op("rdE", 0, 1, 8'h00);
        check("udf.lit", uio_out & 8'h20, 8'h20);
        op("wrrdE", 1, 1, 8'h0F);
        check("wrrdE.lit", uo_out, 8'hF0);

        do_reset();
        op("f11", 1, 0, 8'h11);
        op("f22", 1, 0, 8'h22);
        op("f33", 1, 0, 8'h33);
        op("f44", 1, 0, 8'h44);
        op("wrrdF", 1, 1, 8'hC3);
        check("wrrdF.lit", uio_out & 8'h14, 8'h04);
        op("fr1", 0, 1, 8'h00);
        op("fr2", 0, 1, 8'h00);
        op("fr3", 0, 1, 8'h00);
        check("fr3.lit", uo_out, 8'h3C);
        op("fr4", 0, 1, 8'h00);

        op("pre_ena", 1, 0, 8'h66);
        @(negedge clk);
        ena = 1'b0;
        uio_in = 8'h03;
        repeat (3) @(negedge clk);
        uio_in = '0;
        repeat (4) @(negedge clk);
        check_model("ena0");
        uio_in = 8'h01;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        check_model("ena_rise");
        uio_in = '0;
        repeat (4) @(negedge clk);

        @(negedge clk);
        uio_in = 8'h01;
        ui_in = 8'hEE;
        @(posedge clk);
        uio_in = '0;
        do_reset();
        check_model("midrst");

        uio_in = 8'h01;
        do_reset();
        check_model("held_rel");
        @(negedge clk);
        uio_in = '0;
        repeat (4) @(negedge clk);
        check_model("held_drop");

        op("wr07", 1, 0, 8'h07);
        check("wr07.lit", uo_out, 8'h70);
`ifdef NIBBLE_FIFO_PARITY_EN
        check("par.lit", uio_out & 8'h40, 8'h40);
`else
        check("par.lit", uio_out & 8'h40, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
